cga_vram_arbiter: RTL and testbench
===================================

# cga_vram_arbiter

Time-shares the single CGA video RAM port between the display fetch pipeline and ISA CPU memory cycles in the B8000 window. Display fetches always win; CPU accesses are granted a fixed sequencer slot per character period and are stretched on the ISA bus with wait states via `bus_rdy`. The block sits between the `cga` top level (sequencer `clk_seq`/`vram_read`, CRTC-derived display address) and the external RAM pins.

## Interface
- `USE_BUS_WAIT`, 1: 1 = drive `bus_rdy` low until the CPU access completes; 0 = `bus_rdy` tied high.
- `CPU_SLOT`, 5'd17: `clk_seq` value at which a pending CPU access may take the RAM port.

- `clk` in 1: pixel/sequencer clock, the only clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `clk_seq` in 5: sequencer phase, counts 0..31 and wraps.
- `vram_read` in 1: high = display fetch owns the RAM port this cycle.
- `disp_addr` in 19: display fetch address.
- `bus_a` in 15: CPU offset within the 32K window.
- `bus_mem_cs` in 1: CPU address decodes to the framebuffer.
- `bus_memr_l`, `bus_memw_l` in 1: raw ISA strobes, active-low, asynchronous to `clk`.
- `bus_d` in 8: CPU write data.
- `ram_d` in 8: RAM read data, valid one cycle after the address.
- `ram_a` out 19: RAM address.
- `ram_we_l` out 1: RAM write enable, active-low.
- `ram_dout` out 8: RAM write data.
- `bus_out_mem` out 8: CPU read data.
- `bus_dir_mem` out 1: high while the CPU read is in progress (`bus_mem_cs & ~bus_memr_l`).
- `bus_rdy` out 1: ISA ready.

## Operation
- Strobes pass through a 2-flop synchronizer. Synchronizer flops reset to 1.
- FSM states: IDLE, WAIT_SLOT, ACCESS, CAPTURE, DONE.
- IDLE: on synced strobe low with `bus_mem_cs`, latch `bus_a`, `bus_d` and direction, then go to WAIT_SLOT. If both strobes are low, the write takes precedence.
- WAIT_SLOT: when `clk_seq==CPU_SLOT` and `~vram_read`, go to ACCESS. If `vram_read` is high at `CPU_SLOT`, the display wins and the CPU retries at the next `CPU_SLOT` (32 clocks later).
- ACCESS (1 clock):
  - `ram_a={4'h0,cpu_addr}`.
  - Write: `ram_we_l=0`, `ram_dout=latched data`, then go to DONE.
  - Read: go to CAPTURE.
- CAPTURE (1 clock): register `ram_d` into `bus_out_mem`, then go to DONE.
- DONE: hold until the synced strobe is high, then go to IDLE.
- Outside ACCESS: `ram_a=disp_addr`, `ram_we_l=1`.
- `bus_rdy` when `USE_BUS_WAIT=1`: `~(bus_mem_cs & (~bus_memr_l | ~bus_memw_l)) | done_q`, where `done_q` is the registered (state==DONE). It drops combinationally with the strobe and rises only in DONE.
- Aborted strobe (deasserted before DONE):
  - A latched write still completes, then the FSM returns to IDLE.
  - A pending read is dropped: WAIT_SLOT goes to IDLE.
- `vram_read` asserted during ACCESS is a protocol error. The CPU keeps the port; an assertion flags it.

## Timing
- Reset values:
  - State IDLE.
  - `ram_we_l=1`, `ram_dout=0`, `bus_out_mem=0`, `done_q=0`.
  - `ram_a=disp_addr`.
  - `bus_rdy` follows its formula, so it is high if no strobe is active.
- Strobe to detection: 2 clocks of synchronizer delay plus 1 to latch.
- Grant latency: 0..31 clocks to `CPU_SLOT`, plus 32 for each display conflict.
- Read: ACCESS at T; `bus_out_mem` valid from T+2; DONE and `bus_rdy` high from T+2.
- Write: RAM written at T; DONE at T+1.
- Reset mid-operation: immediate return to IDLE. No RAM write is issued after `reset_n` falls.
- `clk_seq` wrap 31→0 has no special handling.

## Structure
- `cga_pkg`: the state enum (IDLE/WAIT_SLOT/ACCESS/CAPTURE/DONE) and the `CPU_SLOT` default constant.
- Sub-module `cga_sync2`: 2-flop synchronizer with asynchronous active-low reset and a reset value parameter. Instantiated twice, once per strobe.
- Everything else (FSM, latches, muxes) stays in `cga_vram_arbiter`.

## Test plan
- Write 8'hA5 to offset 15'h0123 in IDLE with `vram_read=0` at slot 17 → one cycle of `ram_we_l=0` with `ram_a=19'h00123`, `ram_dout=8'hA5`; `bus_rdy` low until DONE.
- Read offset 15'h0040, RAM model returns 8'h3C → `bus_out_mem=8'h3C` two clocks after ACCESS; `bus_rdy` rises in the same cycle.
- `vram_read=1` at the first `clk_seq=17` → no CPU access that period; grant occurs 32 clocks later; `ram_a` stays `disp_addr` throughout the conflict.
- Read strobe released while in WAIT_SLOT → back to IDLE, no ACCESS cycle, `bus_out_mem` unchanged. Same case with a write → the write still lands at the next slot.
- `reset_n` pulsed low during WAIT_SLOT of a write → `ram_we_l` stays 1, state IDLE, `bus_out_mem=0`.
- `USE_BUS_WAIT=0` → `bus_rdy` constantly 1; read data still appears per the read timing.

Source files
------------

// File: rtl/cga_pkg.sv
// Shared types and constants for the CGA video RAM arbiter.
package cga_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SLOT,
    ST_ACCESS,
    ST_CAPTURE,
    ST_DONE
  } arb_state_e;

  localparam logic [4:0] CPU_SLOT_DEFAULT = 5'd17;

endpackage

// File: rtl/cga_sync2.sv
// Two-flop synchronizer for asynchronous ISA strobes, with selectable reset value.
module cga_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ff_q <= {2{RST_VAL}};
    end else begin
      ff_q <= {ff_q[0], d_i};
    end
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/cga_vram_arbiter.sv
// Shares the CGA video RAM port between display fetches and ISA CPU cycles,
// granting the CPU one sequencer slot per character period.
module cga_vram_arbiter
  import cga_pkg::*;
#(
  parameter bit         USE_BUS_WAIT = 1'b1,
  parameter logic [4:0] CPU_SLOT     = CPU_SLOT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  clk_seq,
  input  logic        vram_read,
  input  logic [18:0] disp_addr,
  input  logic [14:0] bus_a,
  input  logic        bus_mem_cs,
  input  logic        bus_memr_l,
  input  logic        bus_memw_l,
  input  logic [7:0]  bus_d,
  input  logic [7:0]  ram_d,
  output logic [18:0] ram_a,
  output logic        ram_we_l,
  output logic [7:0]  ram_dout,
  output logic [7:0]  bus_out_mem,
  output logic        bus_dir_mem,
  output logic        bus_rdy
);

  logic       memr_s, memw_s;
  arb_state_e state_q, state_d;
  logic [14:0] addr_q;
  logic [7:0]  data_q;
  logic        wr_q;
  logic        cpu_sel_q;
  logic        we_l_q;
  logic [7:0]  rd_data_q;
  logic        done_q;

  cga_sync2 #(.RST_VAL(1'b1)) u_sync_memr (
    .clk_i (clk),
    .rst_ni(reset_n),
    .d_i   (bus_memr_l),
    .q_o   (memr_s)
  );

  cga_sync2 #(.RST_VAL(1'b1)) u_sync_memw (
    .clk_i (clk),
    .rst_ni(reset_n),
    .d_i   (bus_memw_l),
    .q_o   (memw_s)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (bus_mem_cs && (!memw_s || !memr_s)) state_d = ST_WAIT_SLOT;
      // A released read strobe drops the request; a latched write always completes.
      ST_WAIT_SLOT: if (!wr_q && memr_s)                          state_d = ST_IDLE;
                    else if ((clk_seq == CPU_SLOT) && !vram_read) state_d = ST_ACCESS;
      ST_ACCESS:    state_d = wr_q ? ST_DONE : ST_CAPTURE;
      ST_CAPTURE:   state_d = ST_DONE;
      ST_DONE:      if (memr_s && memw_s) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Port-select, write-enable and done flags are decoded from state_d so they
  // line up exactly with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      cpu_sel_q <= 1'b0;
      we_l_q    <= 1'b1;
      rd_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpu_sel_q <= (state_d == ST_ACCESS);
      we_l_q    <= !((state_d == ST_ACCESS) && wr_q);
      done_q    <= (state_d == ST_DONE);
      if ((state_q == ST_IDLE) && (state_d == ST_WAIT_SLOT)) begin
        addr_q <= bus_a;
        data_q <= bus_d;
        wr_q   <= !memw_s;
      end
      if (state_q == ST_CAPTURE) begin
        rd_data_q <= ram_d;
      end
    end
  end

  assign ram_a       = cpu_sel_q ? {4'h0, addr_q} : disp_addr;
  assign ram_we_l    = we_l_q;
  assign ram_dout    = data_q;
  assign bus_out_mem = rd_data_q;
  assign bus_dir_mem = bus_mem_cs & ~bus_memr_l;

  generate
    if (USE_BUS_WAIT) begin : g_wait
      assign bus_rdy = ~(bus_mem_cs & (~bus_memr_l | ~bus_memw_l)) | done_q;
    end else begin : g_nowait
      assign bus_rdy = 1'b1;
    end
  endgenerate

  a_no_display_in_access: assert property (
    @(posedge clk) disable iff (!reset_n) (state_q == ST_ACCESS) |-> !vram_read
  );

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Directed self-checking bench for cga_vram_arbiter (wait-state and no-wait builds).
module tb_cga_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  clk_seq;
  logic        vram_read;
  logic [18:0] disp_addr;
  logic [14:0] bus_a;
  logic        bus_mem_cs;
  logic        bus_memr_l;
  logic        bus_memw_l;
  logic [7:0]  bus_d;
  logic [7:0]  ram_d;

  logic [18:0] ram_a;
  logic        ram_we_l;
  logic [7:0]  ram_dout;
  logic [7:0]  bus_out_mem;
  logic        bus_dir_mem;
  logic        bus_rdy;

  logic [18:0] nw_ram_a;
  logic        nw_ram_we_l;
  logic [7:0]  nw_ram_dout;
  logic [7:0]  nw_bus_out_mem;
  logic        nw_bus_dir_mem;
  logic        nw_bus_rdy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cga_vram_arbiter #(.USE_BUS_WAIT(1'b1), .CPU_SLOT(5'd17)) dut (
    .clk(clk), .reset_n(reset_n), .clk_seq(clk_seq), .vram_read(vram_read),
    .disp_addr(disp_addr), .bus_a(bus_a), .bus_mem_cs(bus_mem_cs),
    .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l), .bus_d(bus_d), .ram_d(ram_d),
    .ram_a(ram_a), .ram_we_l(ram_we_l), .ram_dout(ram_dout),
    .bus_out_mem(bus_out_mem), .bus_dir_mem(bus_dir_mem), .bus_rdy(bus_rdy)
  );

  cga_vram_arbiter #(.USE_BUS_WAIT(1'b0), .CPU_SLOT(5'd17)) dut_nw (
    .clk(clk), .reset_n(reset_n), .clk_seq(clk_seq), .vram_read(vram_read),
    .disp_addr(disp_addr), .bus_a(bus_a), .bus_mem_cs(bus_mem_cs),
    .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l), .bus_d(bus_d), .ram_d(ram_d),
    .ram_a(nw_ram_a), .ram_we_l(nw_ram_we_l), .ram_dout(nw_ram_dout),
    .bus_out_mem(nw_bus_out_mem), .bus_dir_mem(nw_bus_dir_mem), .bus_rdy(nw_bus_rdy)
  );

  function automatic logic [7:0] mem_model(input logic [18:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return (a == 19'h00040) ? 8'h3C : (lo ^ 8'h5A);
  endfunction

  task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: RAM answers the address seen during the cycle, then the
  // sequencer advances and the display address follows it.
  task automatic tick();
    logic [18:0] a;
    a = ram_a;
    @(posedge clk);
    #1;
    ram_d     = mem_model(a);
    clk_seq   = clk_seq + 5'd1;
    disp_addr = 19'h48000 + {14'h0, clk_seq};
    #1;
    chk("nowait_rdy", {18'h0, nw_bus_rdy}, 19'h1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_seq(input logic [4:0] v);
    for (int i = 0; i < 40 && clk_seq != v; i++) tick();
  endtask

  initial begin
    reset_n    = 1'b0;
    clk_seq    = 5'd0;
    vram_read  = 1'b0;
    disp_addr  = 19'h48000;
    bus_a      = '0;
    bus_mem_cs = 1'b0;
    bus_memr_l = 1'b1;
    bus_memw_l = 1'b1;
    bus_d      = '0;
    ram_d      = '0;

    ticks(2);
    chk("rst_we_l",  {18'h0, ram_we_l},    19'h1);
    chk("rst_dout",  {11'h0, ram_dout},    19'h0);
    chk("rst_rdata", {11'h0, bus_out_mem}, 19'h0);
    chk("rst_rdy",   {18'h0, bus_rdy},     19'h1);
    chk("rst_dir",   {18'h0, bus_dir_mem}, 19'h0);
    chk("rst_ram_a", ram_a,                disp_addr);
    reset_n = 1'b1;
    tick();

    // Write A5 to 0123, slot taken at the first clk_seq==17
    bus_a = 15'h0123; bus_d = 8'hA5; bus_mem_cs = 1'b1;
    wait_seq(5'd14);
    bus_memw_l = 1'b0; #1;
    chk("wr_rdy_drop", {18'h0, bus_rdy}, 19'h0);
    ticks(3);
    chk("wr_wait_we",  {18'h0, ram_we_l}, 19'h1);
    chk("wr_wait_rdy", {18'h0, bus_rdy},  19'h0);
    tick();
    chk("wr_acc_we",   {18'h0, ram_we_l}, 19'h0);
    chk("wr_acc_a",    ram_a,             19'h00123);
    chk("wr_acc_dout", {11'h0, ram_dout}, 19'h000A5);
    chk("wr_acc_rdy",  {18'h0, bus_rdy},  19'h0);
    tick();
    chk("wr_done_we",  {18'h0, ram_we_l}, 19'h1);
    chk("wr_done_rdy", {18'h0, bus_rdy},  19'h1);
    chk("wr_done_a",   ram_a,             disp_addr);
    bus_memw_l = 1'b1; #1;
    ticks(4);

    // Read 0040, RAM returns 3C two clocks after ACCESS
    bus_a = 15'h0040;
    wait_seq(5'd14);
    bus_memr_l = 1'b0; #1;
    chk("rd_dir",      {18'h0, bus_dir_mem}, 19'h1);
    chk("rd_rdy_drop", {18'h0, bus_rdy},     19'h0);
    ticks(4);
    chk("rd_acc_a",    ram_a,                19'h00040);
    chk("rd_acc_we",   {18'h0, ram_we_l},    19'h1);
    tick();
    chk("rd_cap_data", {11'h0, bus_out_mem}, 19'h0);
    chk("rd_cap_rdy",  {18'h0, bus_rdy},     19'h0);
    tick();
    chk("rd_data",     {11'h0, bus_out_mem},    19'h0003C);
    chk("rd_rdy",      {18'h0, bus_rdy},        19'h1);
    chk("rd_nw_data",  {11'h0, nw_bus_out_mem}, 19'h0003C);
    bus_memr_l = 1'b1; #1;
    chk("rd_dir_off",  {18'h0, bus_dir_mem}, 19'h0);
    ticks(4);

    // Display owns the port at the first slot; grant comes 32 clocks later
    bus_a = 15'h7ABC; bus_d = 8'h5E;
    wait_seq(5'd14);
    bus_memw_l = 1'b0; #1;
    ticks(3);
    vram_read = 1'b1;
    tick();
    vram_read = 1'b0;
    chk("cf_slot_we", {18'h0, ram_we_l}, 19'h1);
    chk("cf_slot_a",  ram_a,             disp_addr);
    for (int i = 0; i < 31; i++) begin
      tick();
      chk("cf_hold_we",  {18'h0, ram_we_l}, 19'h1);
      chk("cf_hold_a",   ram_a,             disp_addr);
      chk("cf_hold_rdy", {18'h0, bus_rdy},  19'h0);
    end
    tick();
    chk("cf_acc_we",   {18'h0, ram_we_l}, 19'h0);
    chk("cf_acc_a",    ram_a,             19'h07ABC);
    chk("cf_acc_dout", {11'h0, ram_dout}, 19'h0005E);
    tick();
    chk("cf_done_rdy", {18'h0, bus_rdy},  19'h1);
    bus_memw_l = 1'b1; #1;
    ticks(4);

    // Read strobe released while waiting: request dropped
    bus_a = 15'h0010;
    wait_seq(5'd2);
    bus_memr_l = 1'b0; #1;
    ticks(3);
    bus_memr_l = 1'b1; #1;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("ab_rd_we", {18'h0, ram_we_l}, 19'h1);
      chk("ab_rd_a",  ram_a,             disp_addr);
    end
    chk("ab_rd_data", {11'h0, bus_out_mem}, 19'h0003C);

    // Write strobe released while waiting: write still lands at the slot
    bus_a = 15'h0555; bus_d = 8'hC3;
    wait_seq(5'd2);
    bus_memw_l = 1'b0; #1;
    ticks(3);
    bus_memw_l = 1'b1; #1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("ab_wr_wait_we", {18'h0, ram_we_l}, 19'h1);
    end
    tick();
    chk("ab_wr_we",   {18'h0, ram_we_l}, 19'h0);
    chk("ab_wr_a",    ram_a,             19'h00555);
    chk("ab_wr_dout", {11'h0, ram_dout}, 19'h000C3);
    tick();
    chk("ab_wr_end_we", {18'h0, ram_we_l}, 19'h1);
    chk("ab_wr_rdy",    {18'h0, bus_rdy},  19'h1);
    ticks(3);

    // Reset pulsed while a write waits for its slot
    bus_a = 15'h0222; bus_d = 8'h11;
    wait_seq(5'd2);
    bus_memw_l = 1'b0; #1;
    ticks(3);
    reset_n = 1'b0; #1;
    chk("rs_we",    {18'h0, ram_we_l},       19'h1);
    chk("rs_data",  {11'h0, bus_out_mem},    19'h0);
    chk("rs_dout",  {11'h0, ram_dout},       19'h0);
    chk("rs_rdy",   {18'h0, bus_rdy},        19'h0);
    chk("rs_nw",    {11'h0, nw_bus_out_mem}, 19'h0);
    bus_memw_l = 1'b1; #1;
    ticks(2);
    reset_n = 1'b1; #1;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("rs_post_we", {18'h0, ram_we_l}, 19'h1);
      chk("rs_post_a",  ram_a,             disp_addr);
    end
    chk("rs_post_data", {11'h0, bus_out_mem}, 19'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
